// File: rtl/bf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bf_pkg
// Purpose  : Shared opcodes, write-mux select codes and FSM states for the BF core.
// Revision : 1.0
// ============================================================================
package bf_pkg;

    localparam logic [7:0] OP_INC   = 8'h2B;
    localparam logic [7:0] OP_DEC   = 8'h2D;
    localparam logic [7:0] OP_RIGHT = 8'h3E;
    localparam logic [7:0] OP_LEFT  = 8'h3C;
    localparam logic [7:0] OP_OUT   = 8'h2E;
    localparam logic [7:0] OP_IN    = 8'h2C;
    localparam logic [7:0] OP_JZ    = 8'h5B;
    localparam logic [7:0] OP_JNZ   = 8'h5D;
    localparam logic [7:0] OP_HALT  = 8'h00;

    localparam logic [1:0] SEL_INC  = 2'b00;
    localparam logic [1:0] SEL_DEC  = 2'b01;
    localparam logic [1:0] SEL_IN   = 2'b10;
    localparam logic [1:0] SEL_HOLD = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE         = 4'd0,
        S_FETCH        = 4'd1,
        S_DECODE       = 4'd2,
        S_OUT_WAIT     = 4'd3,
        S_IN_WAIT      = 4'd4,
        S_SCAN_F_FETCH = 4'd5,
        S_SCAN_F_DEC   = 4'd6,
        S_SCAN_B_FETCH = 4'd7,
        S_SCAN_B_DEC   = 4'd8,
        S_HALT         = 4'd9
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bf_exec_ctrl_bracket_scan.sv
`default_nettype none
// ============================================================================
// Module   : bf_bracket_scan
// Purpose  : Bracket-nesting counter for forward/backward scans; flags match and error.
// Revision : 1.0
// ============================================================================
module bf_bracket_scan
    import bf_pkg::*;
#(
    parameter int DEPTH_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic       i_dir_back,
    input  logic       i_step,
    input  logic [7:0] i_byte,
    output logic       o_match,
    output logic       o_err
);

    logic [DEPTH_W-1:0] r_depth;
    logic               r_dir_back;
    logic               w_open;
    logic               w_close;
    logic               w_inc;
    logic               w_dec;

    assign w_open  = (i_byte == OP_JZ);
    assign w_close = (i_byte == OP_JNZ);
    // Scanning backwards swaps the roles of the two brackets.
    assign w_inc   = r_dir_back ? w_close : w_open;
    assign w_dec   = r_dir_back ? w_open  : w_close;

    assign o_match = i_step && w_dec && (r_depth == DEPTH_W'(1));
    assign o_err   = i_step && ((i_byte == OP_HALT) || (w_inc && (r_depth == '1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_depth    <= '0;
            r_dir_back <= 1'b0;
        end else if (i_load) begin
            r_depth    <= DEPTH_W'(1);
            r_dir_back <= i_dir_back;
        end else if (i_step) begin
            if (w_inc) begin
                r_depth <= r_depth + 1'b1;
            end else if (w_dec) begin
                r_depth <= r_depth - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bf_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bf_exec_ctrl
// Purpose  : BF execution FSM owning pc/dp; drives tape write strobe and mux select.
// Revision : 1.0
// ============================================================================
module bf_exec_ctrl
    import bf_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DEPTH_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] prog_addr,
    input  logic [7:0]        prog_data,
    output logic [ADDR_W-1:0] tape_addr,
    input  logic [7:0]        tape_rdata,
    output logic              tape_we,
    output logic [1:0]        wdata_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              halted,
    output logic              err
);

    state_t            r_state, w_state_nx, w_adv_state;
    logic [ADDR_W-1:0] r_pc, w_pc_nx, w_pc_inc, w_adv_pc;
    logic [ADDR_W-1:0] r_dp, w_dp_nx;
    logic              r_err, w_err_nx;
    logic              r_out_valid, w_out_valid_nx;
    logic [7:0]        r_out_data, w_out_data_nx;
    logic              w_cell_zero, w_pc_max, w_pc_min;
    logic              w_scan_load, w_scan_back, w_scan_step, w_scan_match, w_scan_err;

    assign w_cell_zero = (tape_rdata == 8'h00);
    assign w_pc_max    = (r_pc == '1);
    assign w_pc_min    = (r_pc == '0);
    assign w_pc_inc    = r_pc + 1'b1;
    // Advancing past the last program address ends execution cleanly.
    assign w_adv_state = w_pc_max ? S_HALT : S_FETCH;
    assign w_adv_pc    = w_pc_max ? r_pc : w_pc_inc;

    assign prog_addr = r_pc;
    assign tape_addr = r_dp;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign err       = r_err;
    assign halted    = (r_state == S_HALT);

    bf_bracket_scan #(.DEPTH_W(DEPTH_W)) u_scan (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_scan_load),
        .i_dir_back (w_scan_back),
        .i_step     (w_scan_step),
        .i_byte     (prog_data),
        .o_match    (w_scan_match),
        .o_err      (w_scan_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pc        <= '0;
            r_dp        <= '0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
        end else begin
            r_state     <= w_state_nx;
            r_pc        <= w_pc_nx;
            r_dp        <= w_dp_nx;
            r_err       <= w_err_nx;
            r_out_valid <= w_out_valid_nx;
            r_out_data  <= w_out_data_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_pc_nx        = r_pc;
        w_dp_nx        = r_dp;
        w_err_nx       = r_err;
        w_out_valid_nx = r_out_valid;
        w_out_data_nx  = r_out_data;
        case (r_state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    w_pc_nx    = '0;
                    w_dp_nx    = '0;
                    w_err_nx   = 1'b0;
                    w_state_nx = S_FETCH;
                end
            end
            S_FETCH: w_state_nx = S_DECODE;
            S_DECODE: begin
                case (prog_data)
                    OP_HALT: w_state_nx = S_HALT;
                    OP_OUT: begin
                        w_out_data_nx  = tape_rdata;
                        w_out_valid_nx = 1'b1;
                        w_state_nx     = S_OUT_WAIT;
                    end
                    OP_IN: w_state_nx = S_IN_WAIT;
                    OP_JZ: begin
                        w_pc_nx    = w_adv_pc;
                        w_state_nx = (w_cell_zero && !w_pc_max) ? S_SCAN_F_FETCH : w_adv_state;
                    end
                    OP_JNZ: begin
                        if (w_cell_zero) begin
                            w_pc_nx    = w_adv_pc;
                            w_state_nx = w_adv_state;
                        end else if (w_pc_min) begin
                            w_err_nx   = 1'b1;
                            w_state_nx = S_HALT;
                        end else begin
                            w_pc_nx    = r_pc - 1'b1;
                            w_state_nx = S_SCAN_B_FETCH;
                        end
                    end
                    default: begin
                        if (prog_data == OP_RIGHT) w_dp_nx = r_dp + 1'b1;
                        if (prog_data == OP_LEFT)  w_dp_nx = r_dp - 1'b1;
                        w_pc_nx    = w_adv_pc;
                        w_state_nx = w_adv_state;
                    end
                endcase
            end
            S_OUT_WAIT: begin
                if (out_ready) begin
                    w_out_valid_nx = 1'b0;
                    w_pc_nx        = w_adv_pc;
                    w_state_nx     = w_adv_state;
                end
            end
            S_IN_WAIT: begin
                if (in_valid) begin
                    w_pc_nx    = w_adv_pc;
                    w_state_nx = w_adv_state;
                end
            end
            S_SCAN_F_FETCH: w_state_nx = S_SCAN_F_DEC;
            S_SCAN_B_FETCH: w_state_nx = S_SCAN_B_DEC;
            S_SCAN_F_DEC: begin
                if (w_scan_err || (!w_scan_match && w_pc_max)) begin
                    w_err_nx   = 1'b1;
                    w_state_nx = S_HALT;
                end else if (w_scan_match) begin
                    w_pc_nx    = w_adv_pc;
                    w_state_nx = w_adv_state;
                end else begin
                    w_pc_nx    = w_pc_inc;
                    w_state_nx = S_SCAN_F_FETCH;
                end
            end
            S_SCAN_B_DEC: begin
                if (w_scan_err || (!w_scan_match && w_pc_min)) begin
                    w_err_nx   = 1'b1;
                    w_state_nx = S_HALT;
                end else if (w_scan_match) begin
                    w_pc_nx    = w_adv_pc;
                    w_state_nx = w_adv_state;
                end else begin
                    w_pc_nx    = r_pc - 1'b1;
                    w_state_nx = S_SCAN_B_FETCH;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Strobes are gated by rst so the reset cycle can never write the tape.
    always_comb begin
        tape_we     = 1'b0;
        wdata_sel   = SEL_HOLD;
        in_ready    = 1'b0;
        w_scan_load = 1'b0;
        w_scan_back = 1'b0;
        w_scan_step = 1'b0;
        if (!rst) begin
            case (r_state)
                S_DECODE: begin
                    if (prog_data == OP_INC) begin
                        tape_we   = 1'b1;
                        wdata_sel = SEL_INC;
                    end else if (prog_data == OP_DEC) begin
                        tape_we   = 1'b1;
                        wdata_sel = SEL_DEC;
                    end else if (prog_data == OP_JZ) begin
                        w_scan_load = w_cell_zero && !w_pc_max;
                    end else if (prog_data == OP_JNZ) begin
                        w_scan_load = !w_cell_zero && !w_pc_min;
                        w_scan_back = 1'b1;
                    end
                end
                S_IN_WAIT: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        tape_we   = 1'b1;
                        wdata_sel = SEL_IN;
                    end
                end
                S_SCAN_F_DEC, S_SCAN_B_DEC: w_scan_step = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
